i2c_slave_stream: RTL and testbench
===================================

Name: i2c_slave_stream

Overview:
Parametrised I2C target (slave) with a byte-stream interface toward local logic. It replaces the fixed single-byte slave and adds:
- input synchronisation and a glitch filter
- qualified START, repeated START and STOP detection
- multi-byte read and write transfers with valid/ready handshakes
- optional SCL clock stretching and optional general-call response
It sits between the open-drain pad cells and a register file or FIFO in the device fabric.

Parameters:
DEFAULT_ADDR, 7'h50, 7-bit device address loaded at reset.
FILTER_LEN, 3, consecutive identical synchronised samples needed before a filtered SCL/SDA level changes (1..15).
STRETCH_EN, 1, 1 = hold SCL low while local side is not ready; 0 = never drive SCL.
GCALL_EN, 0, 1 = also ACK address 7'h00 with write direction.

Ports:
clk, input, 1, system clock; the only clock.
reset, input, 1, synchronous, active-high reset.
scl_in, input, 1, SCL pad level.
scl_oe, output, 1, 1 = pull SCL low.
sda_in, input, 1, SDA pad level.
sda_oe, output, 1, 1 = pull SDA low.
address, input, 7, new device address.
address_latch, input, 1, when high on a clk edge, load address into the device-address register.
rx_data, output, 8, last received data byte.
rx_valid, output, 1, rx_data holds an unconsumed byte.
rx_ready, input, 1, consumer accepts rx_data (transfer when rx_valid && rx_ready).
tx_data, input, 8, next byte to send to the master.
tx_valid, input, 1, tx_data is available.
tx_ready, output, 1, one-cycle pulse: tx_data captured into the shifter.
rw, output, 1, direction of the current transfer (1 = master read).
busy, output, 1, bus is between START and STOP.
selected, output, 1, address matched in the current transfer.
stop_pulse, output, 1, one-cycle pulse on a detected STOP.
overrun, output, 1, one-cycle pulse: a byte was NACKed because the rx holding register was full.
underrun, output, 1, one-cycle pulse: 8'hFF was sent because tx_valid was low.

Behaviour:
- Reset (reset high at a clk edge), effective next cycle:
  - state=IDLE; scl_oe=0, sda_oe=0.
  - rx_data=8'h00; rx_valid=0; rw=0; busy=0; selected=0.
  - all pulses 0; device address=DEFAULT_ADDR.
  - Filters preset to 1.
  - Reset mid-transfer releases both lines on the next cycle.
- Input path:
  - 2-flop synchroniser per line, then the FILTER_LEN sample filter.
  - Edges are taken from the filtered levels.
  - Latency from pad to edge detect is 2+FILTER_LEN cycles.
- Bus conditions, evaluated only while sda_oe=0:
  - START = filtered SDA falls while filtered SCL is high.
  - STOP = filtered SDA rises while filtered SCL is high.
  - START in any state: go to ADDR, bit counter=7, busy=1, selected=0.
  - STOP in any state: go to IDLE, release lines, busy=0, selected=0, stop_pulse.
- Bit timing:
  - Sample SDA on the filtered SCL rising edge.
  - Update sda_oe on the first cycle after the filtered SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits, MSB first. After bit 0:
    - if addr[7:1] equals the device address, or (GCALL_EN && addr==8'h00): rw=addr[0], selected=1, go to ACK_OUT.
    - otherwise go to WAIT_STOP.
  - ACK_OUT: drive sda_oe=1 for the 9th SCL period, released after its falling edge. Next state:
    - rw=0: go to RX.
    - rw=1: go to TX_LOAD.
  - RX: shift 8 bits, then go to RX_ACK.
  - RX_ACK:
    - If rx_valid=0: load rx_data, set rx_valid, ACK, return to RX.
    - If rx_valid=1 and STRETCH_EN: hold scl_oe=1 from the SCL fall after bit 0 until rx_valid clears, then load, ACK, release SCL.
    - If rx_valid=1 and !STRETCH_EN: NACK (sda_oe=0), pulse overrun, discard the byte, go to WAIT_STOP.
    - rx_valid clears on the cycle rx_valid && rx_ready.
  - TX_LOAD, entered in SCL low phase:
    - If tx_valid: capture tx_data, pulse tx_ready.
    - Else if STRETCH_EN: scl_oe=1 until tx_valid.
    - Else: load 8'hFF, pulse underrun.
    - Then go to TX.
  - TX: drive sda_oe=~bit, MSB first, for 8 bits, then release SDA and go to TX_ACK_IN.
  - TX_ACK_IN: sample SDA at the 9th SCL rise.
    - 0 (master ACK): go to TX_LOAD.
    - 1 (master NACK): go to WAIT_STOP.
  - WAIT_STOP: lines released; only START or STOP leave this state.
- Simultaneous events:
  - START/STOP take priority over any pending bit action.
  - address_latch during a transfer updates the register but does not affect an address already matched.
  - rx_ready asserted in the same cycle as an RX_ACK load lets the new byte replace the old one with no NACK.
- Stretch release: scl_oe falls in the cycle after the condition clears.

Decomposition:
- Shared package i2c_pkg holds:
  - state enumeration
  - ADDR_GCALL=7'h00
  - BYTE_MSB=3'd7
  - NACK/ACK bit constants
- One sub-module, i2c_line_filter (synchroniser + FILTER_LEN filter + rise/fall strobes), instantiated twice.

Test Plan:
1. Write 0xA0 (addr 0x50, W), 0x12, 0x34, STOP, with rx_ready pulsed per byte. Expected: ACK on all 3 bytes; rx_data 0x12 then 0x34; stop_pulse once; busy 0 after STOP.
2. Read 0xA1, tx_data=0x5A then 0xC3; master ACKs the first byte and NACKs the second. Expected: SDA shows 01011010, 11000011; tx_ready pulses twice; WAIT_STOP follows the NACK.
3. Address 0x52 W on the bus while the device address is 0x50. Expected: NACK (sda_oe never 1), selected=0, no rx_valid.
4. STRETCH_EN=1 with rx_ready held low for 2 bytes. Expected: SCL held low after the second byte until rx_ready is asserted, then ACK. STRETCH_EN=0: NACK plus overrun pulse.
5. Repeated START: after W 0x50 + 0x07, repeated START, then R 0x50. Expected: rw 0→1; first tx byte captured with no intervening STOP.
6. address_latch with address 0x21, then a transfer to 0x21. Expected: ACK. Then reset during an SDA-low ACK. Expected: sda_oe=0 next cycle and the address returns to 0x50.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared states and constants for the I2C target
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_OUT, RX, RX_ACK, TX_LOAD, TX, TX_ACK_IN, WAIT_STOP
  } state_t;
  localparam logic [6:0] ADDR_GCALL = 7'h00;
  localparam logic [2:0] BYTE_MSB = 3'd7;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-flop synchroniser, FILTER_LEN-sample glitch filter and edge strobes
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic s1_q, s2_q, lvl_q, rise_q, fall_q;
  logic [3:0] cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      lvl_q <= 1'b1;
      cnt_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q <= line_i;
      s2_q <= s1_q;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (s2_q == lvl_q) cnt_q <= '0;
      else if (cnt_q == 4'(FILTER_LEN - 1)) begin
        lvl_q <= s2_q;
        rise_q <= s2_q;
        fall_q <= !s2_q;
        cnt_q <= '0;
      end else cnt_q <= cnt_q + 4'd1;
    end
  end
  assign level_o = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/i2c_slave_stream.sv
// i2c_slave_stream: I2C target with filtered inputs, byte-stream rx/tx handshakes and optional clock stretching
module i2c_slave_stream
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEFAULT_ADDR = 7'h50,
  parameter int FILTER_LEN = 3,
  parameter bit STRETCH_EN = 1'b1,
  parameter bit GCALL_EN = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  output logic       scl_oe,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [6:0] address,
  input  logic       address_latch,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rw,
  output logic       busy,
  output logic       selected,
  output logic       stop_pulse,
  output logic       overrun,
  output logic       underrun
);
  state_t state_q;
  logic [7:0] shreg_q, rx_data_q;
  logic [6:0] dev_q;
  logic [2:0] cnt_q;
  logic scl_oe_q, sda_oe_q, rx_valid_q, rw_q, busy_q, selected_q;
  logic tx_ready_q, stop_q, overrun_q, underrun_q;
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic start_c, stop_c, match_c, rx_full_c;
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(clk), .reset(reset), .line_i(scl_in),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(clk), .reset(reset), .line_i(sda_in),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );
  // our own SDA drive must never be mistaken for a bus condition
  assign start_c = !sda_oe_q && scl_lvl && sda_fall;
  assign stop_c = !sda_oe_q && scl_lvl && sda_rise;
  assign match_c = (shreg_q[6:0] == dev_q) ||
                   (GCALL_EN && shreg_q[6:0] == ADDR_GCALL && sda_lvl == 1'b0);
  assign rx_full_c = rx_valid_q && !rx_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      rx_data_q <= '0;
      dev_q <= DEFAULT_ADDR;
      cnt_q <= BYTE_MSB;
      {scl_oe_q, sda_oe_q, rx_valid_q, rw_q, busy_q, selected_q} <= '0;
      {tx_ready_q, stop_q, overrun_q, underrun_q} <= '0;
    end else begin
      {tx_ready_q, stop_q, overrun_q, underrun_q} <= '0;
      if (address_latch) dev_q <= address;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      if (start_c) begin
        state_q <= ADDR;
        cnt_q <= BYTE_MSB;
        busy_q <= 1'b1;
        selected_q <= 1'b0;
        scl_oe_q <= 1'b0;
      end else if (stop_c) begin
        state_q <= IDLE;
        {scl_oe_q, sda_oe_q, busy_q, selected_q} <= '0;
        stop_q <= 1'b1;
      end else begin
        case (state_q)
          ADDR: if (scl_rise) begin
            shreg_q <= {shreg_q[6:0], sda_lvl};
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q == 3'd0) begin
              state_q <= match_c ? ACK_OUT : WAIT_STOP;
              if (match_c) begin
                rw_q <= sda_lvl;
                selected_q <= 1'b1;
              end
            end
          end
          // first fall drives the ACK, the second one ends the 9th period
          ACK_OUT: if (scl_fall) begin
            sda_oe_q <= !sda_oe_q;
            if (sda_oe_q) begin
              cnt_q <= BYTE_MSB;
              state_q <= rw_q ? TX_LOAD : RX;
            end
          end
          RX: if (scl_rise) begin
            shreg_q <= {shreg_q[6:0], sda_lvl};
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q == 3'd0) state_q <= RX_ACK;
          end
          RX_ACK: if (scl_fall || scl_oe_q) begin
            if (!rx_full_c) begin
              rx_data_q <= shreg_q;
              rx_valid_q <= 1'b1;
              sda_oe_q <= 1'b1;
              scl_oe_q <= 1'b0;
              state_q <= ACK_OUT;
            end else if (STRETCH_EN) scl_oe_q <= 1'b1;
            else begin
              overrun_q <= 1'b1;
              state_q <= WAIT_STOP;
            end
          end
          TX_LOAD: if (tx_valid) begin
            shreg_q <= tx_data;
            tx_ready_q <= 1'b1;
            sda_oe_q <= !tx_data[7];
            scl_oe_q <= 1'b0;
            cnt_q <= BYTE_MSB;
            state_q <= TX;
          end else if (STRETCH_EN) scl_oe_q <= 1'b1;
          else begin
            shreg_q <= 8'hFF;
            underrun_q <= 1'b1;
            sda_oe_q <= 1'b0;
            cnt_q <= BYTE_MSB;
            state_q <= TX;
          end
          TX: if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              sda_oe_q <= 1'b0;
              state_q <= TX_ACK_IN;
            end else begin
              cnt_q <= cnt_q - 3'd1;
              shreg_q <= shreg_q << 1;
              sda_oe_q <= !shreg_q[6];
            end
          end
          TX_ACK_IN: if (scl_rise && sda_lvl == NACK) state_q <= WAIT_STOP;
          else if (scl_fall) state_q <= TX_LOAD;
          default: ;
        endcase
      end
    end
  end
  assign scl_oe = scl_oe_q;
  assign sda_oe = sda_oe_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = tx_ready_q;
  assign rw = rw_q;
  assign busy = busy_q;
  assign selected = selected_q;
  assign stop_pulse = stop_q;
  assign overrun = overrun_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_i2c_slave_stream.sv
// tb_i2c_slave_stream: bus-level master driving directed transfers with an rx scoreboard
module tb_i2c_slave_stream;
  import i2c_pkg::*;
  localparam int Q = 20;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic scl_m = 1'b1, sda_m = 1'b1;
  logic scl_in, sda_in, scl_oe, sda_oe, scl_oe2, sda_oe2;
  assign scl_in = scl_m & ~scl_oe & ~scl_oe2;
  assign sda_in = sda_m & ~sda_oe & ~sda_oe2;
  logic [6:0] address = 7'h00;
  logic address_latch = 1'b0, rx_ready = 1'b1, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00, rx_data, rx_data2;
  logic rx_valid, tx_ready, rw, busy, selected, stop_pulse, overrun, underrun;
  logic rx_valid2, tx_ready2, rw2, busy2, selected2, stop_pulse2, overrun2, underrun2;
  i2c_slave_stream dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .scl_oe(scl_oe), .sda_in(sda_in), .sda_oe(sda_oe),
    .address(address), .address_latch(address_latch), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rw(rw),
    .busy(busy), .selected(selected), .stop_pulse(stop_pulse), .overrun(overrun), .underrun(underrun)
  );
  i2c_slave_stream #(.DEFAULT_ADDR(7'h30), .STRETCH_EN(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .scl_in(scl_in), .scl_oe(scl_oe2), .sda_in(sda_in), .sda_oe(sda_oe2),
    .address(7'h00), .address_latch(1'b0), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .rx_ready(1'b0), .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(tx_ready2), .rw(rw2),
    .busy(busy2), .selected(selected2), .stop_pulse(stop_pulse2), .overrun(overrun2), .underrun(underrun2)
  );
  int total = 0, bad = 0, stop_cnt = 0, txr_cnt = 0, ovr2 = 0, und2 = 0, stretch_max = 0;
  int tx_idx = 0, tx_n = 0;
  logic sda_seen = 1'b0;
  logic [7:0] tx_mem [8];
  logic [7:0] rx_exp [$];
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  task automatic monitor();
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (rx_valid && rx_ready) begin
          if (rx_exp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_unexpected: got %0h expected none", rx_data);
          end else check("rx_data", rx_data, rx_exp.pop_front());
        end
        if (stop_pulse) stop_cnt++;
        if (tx_ready) txr_cnt++;
        if (overrun2) ovr2++;
        if (underrun2) und2++;
        if (sda_oe) sda_seen = 1'b1;
      end
    end
  endtask
  task automatic tx_driver();
    forever begin
      @(negedge clk);
      if (tx_ready) tx_idx++;
      tx_valid = tx_idx < tx_n;
      tx_data = tx_mem[tx_idx[2:0]];
    end
  endtask
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask
  task automatic scl_high();
    int n = 0;
    scl_m = 1'b1;
    while (scl_in !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL scl_timeout: got %0d cycles low expected release", n);
    end
    if (n > stretch_max) stretch_max = n;
  endtask
  task automatic bit_io(input logic b, output logic r);
    sda_m = b;
    wait_q();
    scl_high();
    wait_q();
    r = sda_in;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask
  task automatic start_c();
    sda_m = 1'b1;
    wait_q();
    scl_high();
    wait_q();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask
  task automatic stop_c();
    sda_m = 1'b0;
    wait_q();
    scl_high();
    wait_q();
    sda_m = 1'b1;
    wait_q();
  endtask
  task automatic wr(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(b[i], r);
    bit_io(1'b1, r);
    ack = !r;
  endtask
  task automatic rd(input logic nack, output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      v[i] = r;
    end
    bit_io(nack, r);
  endtask
  initial begin
    logic a;
    logic [7:0] v, b;
    int s0, n;
    fork
      monitor();
      tx_driver();
    join_none
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rw", rw, 0);
    check("rst_busy", busy, 0);
    check("rst_selected", selected, 0);
    check("rst_stop_pulse", stop_pulse, 0);
    start_c();
    check("t1_busy", busy, 1);
    wr(8'hA0, a);
    check("t1_addr_ack", a, 1);
    check("t1_selected", selected, 1);
    rx_exp.push_back(8'h12);
    wr(8'h12, a);
    check("t1_ack_12", a, 1);
    rx_exp.push_back(8'h34);
    wr(8'h34, a);
    check("t1_ack_34", a, 1);
    stop_c();
    repeat (10) @(negedge clk);
    check("t1_stop_cnt", stop_cnt, 1);
    check("t1_busy_after", busy, 0);
    check("t1_rx_drained", rx_exp.size(), 0);
    tx_mem[0] = 8'h5A;
    tx_mem[1] = 8'hC3;
    tx_idx = 0;
    tx_n = 2;
    repeat (3) @(negedge clk);
    s0 = txr_cnt;
    start_c();
    wr(8'hA1, a);
    check("t2_addr_ack", a, 1);
    check("t2_rw", rw, 1);
    rd(1'b0, v);
    check("t2_byte0", v, 8'h5A);
    rd(1'b1, v);
    check("t2_byte1", v, 8'hC3);
    check("t2_tx_ready_cnt", txr_cnt - s0, 2);
    check("t2_wait_stop", 32'(dut.state_q), 32'(WAIT_STOP));
    stop_c();
    sda_seen = 1'b0;
    start_c();
    wr(8'hA4, a);
    check("t3_nack", a, 0);
    check("t3_selected", selected, 0);
    check("t3_sda_never", sda_seen, 0);
    check("t3_rx_valid", rx_valid, 0);
    stop_c();
    rx_ready = 1'b0;
    start_c();
    wr(8'hA0, a);
    rx_exp.push_back(8'h11);
    wr(8'h11, a);
    check("t4_ack_11", a, 1);
    rx_exp.push_back(8'h22);
    stretch_max = 0;
    fork
      wr(8'h22, a);
      begin
        n = 0;
        while (!scl_oe && n < 5000) begin
          @(negedge clk);
          n++;
        end
        check("t4_stretch_seen", scl_oe, 1);
        repeat (200) @(negedge clk);
        check("t4_still_stretched", scl_oe, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    check("t4_ack_after_stretch", a, 1);
    check("t4_stretch_len", 32'(stretch_max > 100), 1);
    stop_c();
    rx_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_rx_drained", rx_exp.size(), 0);
    start_c();
    wr(8'h60, a);
    check("t4n_addr_ack", a, 1);
    wr(8'h11, a);
    check("t4n_ack_11", a, 1);
    s0 = ovr2;
    wr(8'h22, a);
    check("t4n_nack_22", a, 0);
    check("t4n_overrun", ovr2 - s0, 1);
    stop_c();
    start_c();
    wr(8'h61, a);
    rd(1'b1, v);
    check("t4n_underrun_byte", v, 8'hFF);
    check("t4n_underrun", und2, 1);
    stop_c();
    tx_mem[0] = 8'h3C;
    tx_idx = 0;
    tx_n = 1;
    repeat (3) @(negedge clk);
    s0 = stop_cnt;
    n = txr_cnt;
    start_c();
    wr(8'hA0, a);
    check("t5_rw0", rw, 0);
    rx_exp.push_back(8'h07);
    wr(8'h07, a);
    check("t5_ack_07", a, 1);
    start_c();
    wr(8'hA1, a);
    check("t5_rs_ack", a, 1);
    check("t5_rw1", rw, 1);
    rd(1'b1, v);
    check("t5_byte", v, 8'h3C);
    check("t5_tx_ready", txr_cnt - n, 1);
    check("t5_no_stop", stop_cnt - s0, 0);
    stop_c();
    address = 7'h21;
    address_latch = 1'b1;
    @(negedge clk);
    address_latch = 1'b0;
    start_c();
    wr(8'h42, a);
    check("t6_new_addr_ack", a, 1);
    stop_c();
    start_c();
    b = 8'h42;
    for (int i = 7; i >= 0; i--) bit_io(b[i], a);
    sda_m = 1'b1;
    wait_q();
    check("t6_ack_driven", sda_oe, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_reset_release", sda_oe, 0);
    check("t6_reset_busy", busy, 0);
    scl_high();
    wait_q();
    scl_m = 1'b0;
    wait_q();
    stop_c();
    repeat (10) @(negedge clk);
    start_c();
    wr(8'hA0, a);
    check("t6_default_addr", a, 1);
    stop_c();
    repeat (10) @(negedge clk);
    check("final_rx_drained", rx_exp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
